// File: rtl/fnd_pkg.sv
// fnd_pkg: constants shared by the FND (seven-segment) display blocks.
//   - default parameter values for fnd_scan_ctrl
//   - segment bit order {a..g} used by fnd_dec and the scanner (a = MSB)
//   - ENB_OFF(): idle level of a digit-enable bus for a given polarity
package fnd_pkg;

  localparam int FND_NUM_DIGIT    = 6;
  localparam int FND_SEG_W        = 7;
  localparam int FND_BRIGHT_W     = 3;
  localparam int FND_BLINK_FRAMES = 64;
  localparam bit FND_ENB_ACT_LOW  = 1'b1;
  localparam int FND_MAX_DIGIT    = 16;

  // Segment vector is {a,b,c,d,e,f,g}: a sits in the MSB, g in bit 0.
  localparam int FND_SEG_IDX_A = 6;
  localparam int FND_SEG_IDX_G = 0;

  // Idle (all digits off) enable pattern for an n-digit bus, returned
  // FND_MAX_DIGIT wide; callers slice the low n bits.
  function automatic logic [FND_MAX_DIGIT-1:0] ENB_OFF(input int n, input bit act_low);
    logic [FND_MAX_DIGIT-1:0] v;
    v = '0;
    for (int i = 0; i < FND_MAX_DIGIT; i++)
      if (i < n) v[i] = act_low;
    return v;
  endfunction

endpackage

// File: rtl/fnd_tick_gen.sv
// fnd_tick_gen: clock-enable tick generator.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : synchronous clear of the divider (tick suppressed)
//   i_div      : clk cycles per tick; 0 behaves as 1
//   o_tick     : combinational one-cycle tick, high when div_cnt >= D-1
module fnd_tick_gen #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] div_eff;

  // ">=" rather than "==" so that lowering i_div below the running count
  // fires a tick right away instead of waiting for a 32-bit wrap.
  always_comb begin
    div_eff   = (i_div == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : i_div;
    o_tick    = ~i_clr & (div_cnt_q >= (div_eff - 1'b1));
    div_cnt_d = div_cnt_q + 1'b1;
    if (i_clr || o_tick) div_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div_cnt_q <= '0;
    else        div_cnt_q <= div_cnt_d;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: multiplexed seven-segment scan controller.
//   clk, rst_n   : clock, async active-low reset
//   i_en         : 1 = scan, 0 = blank and hold counters cleared
//   i_scan_div   : clk cycles per tick (0 treated as 1)
//   i_bright     : on-ticks per 2^BRIGHT_W-tick digit slot (0 = blank)
//   i_digit_seg  : digit k segments at [k*SEG_W +: SEG_W]
//   i_dp, i_blink: per-digit decimal point / blink enable
//   o_seg, o_seg_dp, o_seg_enb, o_scan_idx : registered pin drive
//   o_frame      : one-cycle pulse after each completed frame
// Display data is latched into shadow registers once per frame so a
// frame never shows a mix of old and new digits.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int NUM_DIGIT    = FND_NUM_DIGIT,
  parameter int SEG_W        = FND_SEG_W,
  parameter int BRIGHT_W     = FND_BRIGHT_W,
  parameter int BLINK_FRAMES = FND_BLINK_FRAMES,
  parameter bit ENB_ACT_LOW  = FND_ENB_ACT_LOW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_en,
  input  logic [31:0]                i_scan_div,
  input  logic [BRIGHT_W-1:0]        i_bright,
  input  logic [NUM_DIGIT*SEG_W-1:0] i_digit_seg,
  input  logic [NUM_DIGIT-1:0]       i_dp,
  input  logic [NUM_DIGIT-1:0]       i_blink,
  output logic [SEG_W-1:0]           o_seg,
  output logic                       o_seg_dp,
  output logic [NUM_DIGIT-1:0]       o_seg_enb,
  output logic [$clog2(NUM_DIGIT)-1:0] o_scan_idx,
  output logic                       o_frame
);

  localparam int IDX_W = $clog2(NUM_DIGIT);
  localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FND_MAX_DIGIT-1:0] ENB_OFF_FULL = ENB_OFF(NUM_DIGIT, ENB_ACT_LOW);
  localparam logic [NUM_DIGIT-1:0]     ENB_IDLE     = ENB_OFF_FULL[NUM_DIGIT-1:0];

  logic tick, sub_wrap, dig_last, frame_end, dig_on;

  logic [BRIGHT_W-1:0] sub_cnt_q, sub_cnt_d;
  logic [IDX_W-1:0]    dig_idx_q, dig_idx_d;
  logic [BC_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic                blink_ph_q, blink_ph_d;

  logic [NUM_DIGIT-1:0][SEG_W-1:0] shd_seg_q, shd_seg_d;
  logic [NUM_DIGIT-1:0]            shd_dp_q, shd_dp_d;
  logic [NUM_DIGIT-1:0]            shd_blink_q, shd_blink_d;

  logic [SEG_W-1:0]     seg_q, seg_d;
  logic                 seg_dp_q, seg_dp_d;
  logic [NUM_DIGIT-1:0] seg_enb_q, seg_enb_d;
  logic [IDX_W-1:0]     scan_idx_q, scan_idx_d;
  logic                 frame_q, frame_d;

  fnd_tick_gen #(.DIV_W(32)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (~i_en),
    .i_div  (i_scan_div),
    .o_tick (tick)
  );

  // tick is already masked by ~i_en inside the tick generator.
  assign sub_wrap  = tick & (sub_cnt_q == '1);
  assign dig_last  = (dig_idx_q == IDX_W'(NUM_DIGIT - 1));
  assign frame_end = sub_wrap & dig_last;

  // Scan / blink counters
  always_comb begin
    sub_cnt_d   = sub_cnt_q;
    dig_idx_d   = dig_idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (!i_en) begin
      sub_cnt_d   = '0;
      dig_idx_d   = '0;
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (tick) begin
      sub_cnt_d = sub_cnt_q + 1'b1;
      if (sub_wrap) dig_idx_d = dig_last ? '0 : dig_idx_q + 1'b1;
      if (frame_end) begin
        if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_d = '0;
          blink_ph_d  = ~blink_ph_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end
  end

  // Shadow: track inputs while disabled so re-enable shows fresh data at once.
  always_comb begin
    shd_seg_d   = shd_seg_q;
    shd_dp_d    = shd_dp_q;
    shd_blink_d = shd_blink_q;
    if (!i_en || frame_end) begin
      shd_seg_d   = i_digit_seg;
      shd_dp_d    = i_dp;
      shd_blink_d = i_blink;
    end
  end

  // Output stage. XOR against the idle pattern yields a one-hot enable of
  // the right polarity for either ENB_ACT_LOW setting.
  always_comb begin
    dig_on     = i_en & (sub_cnt_q < i_bright) & ~(shd_blink_q[dig_idx_q] & blink_ph_q);
    seg_d      = dig_on ? shd_seg_q[dig_idx_q] : '0;
    seg_dp_d   = dig_on & shd_dp_q[dig_idx_q];
    seg_enb_d  = dig_on ? (ENB_IDLE ^ (NUM_DIGIT'(1) << dig_idx_q)) : ENB_IDLE;
    scan_idx_d = dig_idx_q;
    frame_d    = frame_end;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sub_cnt_q   <= '0;
      dig_idx_q   <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      shd_seg_q   <= '0;
      shd_dp_q    <= '0;
      shd_blink_q <= '0;
      seg_q       <= '0;
      seg_dp_q    <= 1'b0;
      seg_enb_q   <= ENB_IDLE;
      scan_idx_q  <= '0;
      frame_q     <= 1'b0;
    end else begin
      sub_cnt_q   <= sub_cnt_d;
      dig_idx_q   <= dig_idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      shd_seg_q   <= shd_seg_d;
      shd_dp_q    <= shd_dp_d;
      shd_blink_q <= shd_blink_d;
      seg_q       <= seg_d;
      seg_dp_q    <= seg_dp_d;
      seg_enb_q   <= seg_enb_d;
      scan_idx_q  <= scan_idx_d;
      frame_q     <= frame_d;
    end

  assign o_seg      = seg_q;
  assign o_seg_dp   = seg_dp_q;
  assign o_seg_enb  = seg_enb_q;
  assign o_scan_idx = scan_idx_q;
  assign o_frame    = frame_q;

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Parametrised multi-digit seven-segment scan controller with programmable scan rate, PWM brightness, per-digit blink and tear-free frame latching. It sits between the per-digit `fnd_dec` outputs and the board FND pins, and replaces the fixed six-digit, derived-clock scanner. All logic runs on `clk` and is advanced by a single-cycle clock-enable tick; no generated clocks are used.

## Interface
- `NUM_DIGIT`, 6, number of multiplexed digits (2..16).
- `SEG_W`, 7, segment bits per digit, ordered {a..g}, active-high.
- `BRIGHT_W`, 3, brightness resolution; each digit slot is 2^BRIGHT_W ticks long.
- `BLINK_FRAMES`, 64, frames per blink half-period (≥1).
- `ENB_ACT_LOW`, 1, 1 = common-node enables active-low.
- `clk`  in  1  system clock (50 MHz board clock).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_en`  in  1  1 = scanning; 0 = all digits off, counters cleared.
- `i_scan_div`  in  32  clk cycles per tick; 0 is treated as 1.
- `i_bright`  in  BRIGHT_W  on-ticks per slot; 0 = blank.
- `i_digit_seg`  in  NUM_DIGIT*SEG_W  digit k at [k*SEG_W +: SEG_W].
- `i_dp`  in  NUM_DIGIT  decimal point per digit, active-high.
- `i_blink`  in  NUM_DIGIT  1 = digit k blinks.
- `o_seg`  out  SEG_W  segment drive of the current digit.
- `o_seg_dp`  out  1  decimal point of the current digit.
- `o_seg_enb`  out  NUM_DIGIT  one-hot (polarity per ENB_ACT_LOW) digit enable.
- `o_scan_idx`  out  $clog2(NUM_DIGIT)  digit currently driven.
- `o_frame`  out  1  one-cycle pulse when a frame completes.

## Operation
- Tick: `div_cnt` counts 0..D-1, where D = max(i_scan_div, 1); `tick` = 1 when div_cnt ≥ D-1, then div_cnt←0. If D is lowered so div_cnt ≥ D-1, tick fires on the next cycle.
- Slot: on tick, `sub_cnt` increments modulo 2^BRIGHT_W. When sub_cnt wraps, `dig_idx` increments; it wraps NUM_DIGIT-1→0.
- Frame: the tick that wraps dig_idx to 0 raises `frame_end`. `blink_cnt` counts frame_end modulo BLINK_FRAMES; on its wrap `blink_ph` toggles.
- Shadow: `shd_seg`, `shd_dp` and `shd_blink` load from the inputs on frame_end, and continuously while i_en=0. Input changes mid-frame are not visible until the next frame.
- Digit on: the digit is on when i_en & (sub_cnt < i_bright) & ~(shd_blink[dig_idx] & blink_ph).
- Outputs: o_seg = on ? shd_seg[dig_idx] : 0, and likewise for o_seg_dp. o_seg_enb asserts bit dig_idx only when on; otherwise all bits are inactive. o_scan_idx = dig_idx.
- i_en=0: div_cnt, sub_cnt, dig_idx, blink_cnt and blink_ph clear synchronously. Scanning restarts from digit 0, sub 0 on the cycle i_en returns to 1.
- i_bright is sampled live, so the duty cycle takes effect from the current slot.

## Timing
- All outputs are registered. Outputs at cycle t+1 reflect the counter and shadow state at cycle t.
- o_frame asserts the cycle after frame_end, for exactly one cycle.
- Slot length is D·2^BRIGHT_W clk cycles; frame length is NUM_DIGIT times the slot length.
- The first frame after reset is blank, because the shadow holds zeros until the first frame_end. If i_en=0 during reset release, the shadow is already loaded.
- Reset values: o_seg=0, o_seg_dp=0, o_seg_enb all inactive ({NUM_DIGIT{1}} when ENB_ACT_LOW), o_scan_idx=0, o_frame=0. All internal counters and the shadow are 0.
- Async reset mid-scan clears everything immediately. Outputs are inactive while rst_n=0.

## Structure
- Shared package `fnd_pkg`: default parameter constants, the `ENB_OFF(n, act_low)` function, and the segment bit-order constant shared with `fnd_dec`.
- Sub-module `fnd_tick_gen` (div_cnt and tick with the D=0→1 rule), reused by future counter blocks in place of the derived-clock oscillator.
- Scan counters, shadow registers, blink logic and the output register stay in `fnd_scan_ctrl`.

## Test plan
- Reset sequence: NUM_DIGIT=6, scan_div=1, bright=7, i_en=1, all segs 7'h7E. Outputs are at reset values; frame 0 is blank. From frame 1, o_seg_enb walks 111110→011111, with each digit on for 7 of 8 cycles.
- Duty cycle: bright=3, scan_div=4. Each 32-cycle slot has enb active for 12 cycles, then inactive for 20.
- Blink: BLINK_FRAMES=2, i_blink=6'b000001. Digit 0 is on for 2 frames and off for 2 frames; other digits are unaffected, and o_frame pulses once per frame.
- Tear-free update: change i_digit_seg mid-frame. o_seg does not change until the first slot after the next o_frame.
- Enable toggle: drop i_en at digit 3, then raise it. enb goes inactive the next cycle, and scanning resumes at digit 0 with the new shadow visible at once.
- Scan_div edge cases: set scan_div=0 and confirm tick equals scan_div=1. Drop scan_div from 100 to 5 with div_cnt=50 and confirm a tick on the next cycle.
